// File: rtl/lif_neuron_array_if.sv
// Request/result bundle for the LIF neuron array.
// master: issues updates and config (clear_req, in_*, threshold, leak_shift), observes in_ready and results.
// slave : the neuron array itself.
interface lif_neuron_array_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 2
);
  logic                    clear_req;
  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        in_idx;
  logic signed [WIDTH-1:0] sum_wx;
  logic [WIDTH-2:0]        threshold;
  logic [2:0]              leak_shift;
  logic                    out_valid;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_spike;
  logic signed [WIDTH-1:0] out_u;

  modport master (
    output clear_req, in_valid, in_idx, sum_wx, threshold, leak_shift,
    input  in_ready, out_valid, out_idx, out_spike, out_u
  );

  modport slave (
    input  clear_req, in_valid, in_idx, sum_wx, threshold, leak_shift,
    output in_ready, out_valid, out_idx, out_spike, out_u
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire membrane engine for N_NEURONS neurons.
// Each accepted request applies post-spike reset, leak, saturating integration,
// threshold compare and refractory bookkeeping to one neuron, result registered.
// Ports: clk, reset (async, active-high), bus (lif_neuron_array_if.slave):
//   clear_req restarts the zeroing sweep; in_valid/in_ready/in_idx/sum_wx request;
//   threshold/leak_shift config; out_valid/out_idx/out_spike/out_u result.
module lif_neuron_array #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned REFRACT    = 2,
  parameter int unsigned RESET_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  lif_neuron_array_if.slave bus
);

  localparam int unsigned RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int unsigned XW = WIDTH + 1;
  localparam logic signed [XW-1:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {2'b11, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               in_ready_q;
  logic               clr_en_c;
  logic               idx_ok_c;
  logic               accept_c;

  logic signed [WIDTH-1:0] u_q      [N_NEURONS];
  logic                    spiked_q [N_NEURONS];
  logic [RW-1:0]           refr_q   [N_NEURONS];

  logic                    out_valid_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic                    out_spike_q;
  logic signed [WIDTH-1:0] out_u_q;

  // Clamp a WIDTH+1 intermediate into the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return x[WIDTH-1:0];
  endfunction

  // Out-of-range indices exist only when N_NEURONS is not a power of two.
  if (N_NEURONS < (1 << IDX_W)) begin : g_idx_chk
    assign idx_ok_c = (bus.in_idx < IDX_W'(N_NEURONS));
  end else begin : g_idx_full
    assign idx_ok_c = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      in_ready_q <= (state_d == S_RUN);
    end
  end

  // Next state: INIT zeroes one entry per cycle; clear_req restarts the sweep from anywhere.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    clr_en_c = 1'b0;
    case (state_q)
      S_INIT: begin
        clr_en_c = 1'b1;
        if (sweep_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = S_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      S_RUN:   ;
      default: state_d = S_INIT;
    endcase
    if (bus.clear_req) begin
      state_d = S_INIT;
      sweep_d = '0;
    end
  end

  // A request coinciding with clear_req is swallowed.
  assign accept_c = bus.in_valid && in_ready_q && !bus.clear_req && idx_ok_c;

  logic signed [WIDTH-1:0] u_cur, sub_c, acc_c;
  logic                    spk_cur, spike_c;
  logic [RW-1:0]           refr_cur, refr_nxt;
  logic signed [XW-1:0]    u_x, thr_x, base_x, leaked_x, inp_x, acc_x;

  // Neuron update datapath, all intermediates one bit wider than the potential.
  always_comb begin
    u_cur    = u_q[bus.in_idx];
    spk_cur  = spiked_q[bus.in_idx];
    refr_cur = refr_q[bus.in_idx];
    u_x      = {u_cur[WIDTH-1], u_cur};
    thr_x    = {2'b00, bus.threshold};
    sub_c    = sat(u_x - thr_x);
    base_x   = u_x;
    if (spk_cur) begin
      if (RESET_MODE != 0) base_x = '0;
      else                 base_x = {sub_c[WIDTH-1], sub_c};
    end
    if (bus.leak_shift == 3'd0) leaked_x = base_x;
    else                        leaked_x = base_x - (base_x >>> bus.leak_shift);
    inp_x    = (refr_cur != '0) ? '0 : {bus.sum_wx[WIDTH-1], bus.sum_wx};
    acc_c    = sat(leaked_x + inp_x);
    acc_x    = {acc_c[WIDTH-1], acc_c};
    spike_c  = (refr_cur == '0) && (acc_x >= thr_x);
    if (spike_c)              refr_nxt = RW'(REFRACT);
    else if (refr_cur != '0)  refr_nxt = refr_cur - RW'(1);
    else                      refr_nxt = '0;
  end

  // Neuron state and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        u_q[i]      <= '0;
        spiked_q[i] <= 1'b0;
        refr_q[i]   <= '0;
      end
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_spike_q <= 1'b0;
      out_u_q     <= '0;
    end else begin
      out_valid_q <= accept_c;
      if (clr_en_c) begin
        u_q[sweep_q]      <= '0;
        spiked_q[sweep_q] <= 1'b0;
        refr_q[sweep_q]   <= '0;
      end
      if (accept_c) begin
        u_q[bus.in_idx]      <= acc_c;
        spiked_q[bus.in_idx] <= spike_c;
        refr_q[bus.in_idx]   <= refr_nxt;
        out_idx_q            <= bus.in_idx;
        out_spike_q          <= spike_c;
        out_u_q              <= acc_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_spike = out_spike_q;
  assign bus.out_u     = out_u_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: dut_a (subtract-reset, no refractory)
// and dut_b (zero-reset, refractory 2) share stimulus, selected by sel.
module tb_lif_neuron_array;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic clear_req, in_valid;
  logic [1:0]        in_idx;
  logic signed [7:0] sum_wx;
  logic [6:0]        threshold;
  logic [2:0]        leak_shift;

  logic              o_valid, o_spike, o_ready;
  logic [1:0]        o_idx;
  logic signed [7:0] o_u;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lif_neuron_array_if #(.WIDTH(8), .IDX_W(2)) ifa ();
  lif_neuron_array_if #(.WIDTH(8), .IDX_W(2)) ifb ();

  lif_neuron_array #(.WIDTH(8), .N_NEURONS(4), .IDX_W(2), .REFRACT(0), .RESET_MODE(0))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  lif_neuron_array #(.WIDTH(8), .N_NEURONS(4), .IDX_W(2), .REFRACT(2), .RESET_MODE(1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifa.clear_req  = clear_req & ~sel;
  assign ifa.in_valid   = in_valid & ~sel;
  assign ifa.in_idx     = in_idx;
  assign ifa.sum_wx     = sum_wx;
  assign ifa.threshold  = threshold;
  assign ifa.leak_shift = leak_shift;
  assign ifb.clear_req  = clear_req & sel;
  assign ifb.in_valid   = in_valid & sel;
  assign ifb.in_idx     = in_idx;
  assign ifb.sum_wx     = sum_wx;
  assign ifb.threshold  = threshold;
  assign ifb.leak_shift = leak_shift;

  assign o_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign o_spike = sel ? ifb.out_spike : ifa.out_spike;
  assign o_ready = sel ? ifb.in_ready  : ifa.in_ready;
  assign o_idx   = sel ? ifb.out_idx   : ifa.out_idx;
  assign o_u     = sel ? ifb.out_u     : ifa.out_u;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One accepted update; consecutive calls issue on consecutive edges.
  task automatic upd(input string tag, input int idx, input int sum, input int thr,
                     input int sh, input int eu, input int es);
    @(negedge clk);
    in_idx     = 2'(idx);
    sum_wx     = 8'(sum);
    threshold  = 7'(thr);
    leak_shift = 3'(sh);
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_v"},   int'(o_valid), 1);
    check({tag, "_idx"}, int'(o_idx),   idx);
    check({tag, "_u"},   int'(o_u),     eu);
    check({tag, "_s"},   int'(o_spike), es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; reset = 1'b1; clear_req = 1'b0; in_valid = 1'b0;
    in_idx = '0; sum_wx = '0; threshold = '0; leak_shift = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_u",     int'(o_u),     0);
    check("rst_spike", int'(o_spike), 0);
    check("rst_ready", int'(o_ready), 0);

    // INIT sweep: ready low for exactly four cycles.
    @(negedge clk);
    reset = 1'b0;
    #1 check("init_rdy0", int'(o_ready), 0);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      check("init_rdy0", int'(o_ready), 0);
    end
    @(posedge clk); #1;
    check("init_rdy1", int'(o_ready), 1);

    upd("t1", 0, 10, 20, 0, 10, 0);
    @(posedge clk); #1;
    check("hold_v", int'(o_valid), 0);
    check("hold_u", int'(o_u), 10);

    // Fire then subtract threshold, with an idle gap, then back-to-back on a fresh neuron.
    upd("gap_a", 1, 25, 20, 0, 25, 1);
    @(posedge clk);
    upd("gap_b", 1, 0, 20, 0, 5, 0);
    upd("b2b_a", 3, 25, 20, 0, 25, 1);
    upd("b2b_b", 3, 0, 20, 0, 5, 0);

    // Leak by half.
    upd("set_m7", 3, -12, 20, 0, -7, 0);
    upd("leak_p", 0, 0, 20, 1, 5, 0);
    upd("leak_n", 3, 0, 20, 1, -3, 0);

    // Positive saturation.
    upd("satp_a", 2, 100, 127, 0, 100, 0);
    upd("satp_b", 2, 100, 127, 0, 127, 1);

    // Zero-reset with two refractory updates.
    sel = 1'b1;
    upd("rf_0", 0, 30, 20, 0, 30, 1);
    upd("rf_1", 0, 50, 20, 0, 0, 0);
    upd("rf_2", 0, 50, 20, 0, 0, 0);
    upd("rf_3", 0, 50, 20, 0, 50, 1);
    @(negedge clk);
    sel = 1'b0;

    // clear_req in a running stream.
    in_idx = 2'd0; sum_wx = 8'sd1; threshold = 7'd20; leak_shift = 3'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("clr_prev_v", int'(o_valid), 1);
    check("clr_prev_u", int'(o_u), 6);
    in_idx = 2'd1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear_req = 1'b0;
    check("clr_same_v", int'(o_valid), 0);
    check("clr_rdy0", int'(o_ready), 0);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      check("clr_rdy0", int'(o_ready), 0);
    end
    @(posedge clk); #1;
    check("clr_rdy1", int'(o_ready), 1);
    for (int i = 0; i < 4; i++) upd("clr_zero", i, 0, 20, 0, 0, 0);

    // Negative saturation on a cleared neuron.
    upd("satn_a", 0, -100, 127, 0, -100, 0);
    upd("satn_b", 0, -100, 127, 0, -128, 0);

    // Async reset mid-stream.
    @(negedge clk);
    in_idx = 2'd2; sum_wx = 8'sd1; threshold = 7'd20; leak_shift = 3'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("ar_pre_v", int'(o_valid), 1);
    check("ar_pre_u", int'(o_u), 1);
    #1 reset = 1'b1;
    #1;
    check("ar_v",   int'(o_valid), 0);
    check("ar_u",   int'(o_u),     0);
    check("ar_idx", int'(o_idx),   0);
    check("ar_rdy", int'(o_ready), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
